// File: rtl/serial_add_sequencer.sv
// Bit-serial adder sequencer: loads two WIDTH-bit operands, adds them LSB first
// through a single full-adder slice plus carry flop, and presents {cout,sum} with a done pulse.
module serial_add_sequencer #(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, done_q;

    logic             bit_sum, bit_carry, last_bit;

    // The single full-adder slice that every SHIFT cycle reuses.
    assign bit_sum   = sa_q[0] ^ sb_q[0] ^ c_q;
    assign bit_carry = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
    assign last_bit  = (cnt_q == LAST_BIT);

    always_comb begin
        sa_d  = sa_q;
        sb_d  = sb_q;
        sr_d  = sr_q;
        c_d   = c_q;
        cnt_d = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    sa_d  = a_i;
                    sb_d  = b_i;
                    c_d   = cin_i;
                    sr_d  = '0;
                    cnt_d = '0;
                end
            end
            SHIFT: begin
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                c_d   = bit_carry;
                sr_d  = {bit_sum, sr_q[WIDTH-1:1]};
                // Hold at the final count so a power-of-two WIDTH never wraps.
                cnt_d = last_bit ? cnt_q : cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sa_q  <= sa_d;
            sb_q  <= sb_d;
            sr_q  <= sr_d;
            c_q   <= c_d;
            cnt_q <= cnt_d;
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sr_q;
    assign cout_o = c_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized
// run, all compared every cycle against an operation-level model of {cout,sum}.
module tb_serial_add_sequencer;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst, start, cin;
    logic [W-1:0] a, b, sum;
    logic         busy, done, cout;

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b), .cin_i(cin),
        .busy_o(busy), .done_o(done), .sum_o(sum), .cout_o(cout)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Model: an operation is "active" for W+1 edges after acceptance; result is plain addition.
    bit           m_live = 0;
    bit           m_act  = 0;
    int           m_ph   = 0;
    logic [W:0]   m_res  = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1;
            m_act  = 0;
            m_res  = '0;
        end else if (m_act) begin
            m_ph++;
            if (m_ph == W + 1) m_act = 0;
        end else if (start) begin
            m_act = 1;
            m_ph  = 0;
            m_res = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            bit eb, ed;
            eb = m_act && (m_ph < W);
            ed = m_act && (m_ph == W);
            chk("busy", (W+1)'(busy), (W+1)'(eb));
            chk("done", (W+1)'(done), (W+1)'(ed));
            if (!eb) chk("result", {cout, sum}, m_res);
        end
    end

    // Call with DUT idle; returns with DUT idle again.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic [W:0] exp, input string nm);
        int got, nbusy;
        got = -1; nbusy = 0;
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom);
        for (int k = 1; k <= W + 10; k++) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            if (done) begin got = k; break; end
        end
        chk({nm, "_latency"}, (W+1)'(got), (W+1)'(W));
        chk({nm, "_busycycles"}, (W+1)'(nbusy), (W+1)'(W));
        chk({nm, "_sum"}, {cout, sum}, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        int dq[$];
        int exp_edges[4] = '{64, 130, 196, 262};

        rst = 1'b1; start = 1'b1; a = '1; b = '1; cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", {cout, sum}, '0);
        chk("reset_busy", (W+1)'(busy), '0);
        chk("reset_done", (W+1)'(done), '0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_idle", (W+1)'(busy), '0);

        run_op('1, 64'd1, 1'b0, {1'b1, 64'd0}, "allones_plus1");
        run_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, {1'b1, 64'd0}, "pattern");
        repeat (3) @(posedge clk);
        #1;
        chk("hold_prev", {cout, sum}, {1'b1, 64'd0});
        run_op(64'd5, 64'd7, 1'b0, 65'd12, "small");

        // Randomized: operands churn every cycle, start pulses at random, rare resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom);
            start = ($urandom_range(0, 5) == 0);
            rst   = ($urandom_range(0, 999) == 0);
        end
        rst = 1'b0; start = 1'b0;
        repeat (W + 3) @(posedge clk);
        #1;

        // Back-to-back with start held.
        a = 64'd3; b = 64'd4; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k < 300; k++) begin
            @(posedge clk); #1;
            if (done) begin
                dq.push_back(k);
                chk("b2b_sum", {cout, sum}, 65'd7);
            end
        end
        start = 1'b0;
        chk("b2b_count", (W+1)'(dq.size()), (W+1)'(4));
        for (int i = 0; i < 4; i++)
            chk("b2b_edge", (W+1)'((i < dq.size()) ? dq[i] : -1), (W+1)'(exp_edges[i]));
        repeat (W + 3) @(posedge clk);
        #1;

        // Abort with reset at E30.
        a = 64'hDEAD_BEEF_0000_1111; b = 64'h1234; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out", {cout, sum}, '0);
        chk("abort_busy", (W+1)'(busy), '0);
        begin
            int nd;
            nd = 0;
            for (int k = 0; k < 80; k++) begin
                @(posedge clk); #1;
                if (done) nd++;
            end
            chk("abort_nodone", (W+1)'(nd), '0);
        end
        run_op(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b1,
               {1'b1, 64'h0000_0001_0000_0001}, "after_abort");

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/serial_add_sequencer.md
# serial_add_sequencer

Controller that sequences a bit-serial shift-register datapath to add two WIDTH-bit operands one bit per clock, LSB first. It sits in front of the 1-bit full adder and the serial shift registers, and gives the rest of the design a start/busy/done handshake with parallel operand load and parallel result unload. It is the low-area alternative to the parallel 64-bit adder and uses a single full-adder slice plus a carry flip-flop.

## Interface
- WIDTH, 64, operand/result width in bits; legal range WIDTH >= 2
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset; overrides every other input
- start  input  1  request a new addition; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepting edge only
- b  input  WIDTH  operand B; captured on the accepting edge only
- cin  input  1  carry-in; captured on the accepting edge only
- busy  output  1  high while bits are being shifted (SHIFT state)
- done  output  1  single-cycle pulse; sum/cout are valid
- sum  output  WIDTH  result register
- cout  output  1  final carry-out

## Operation
- Internal state: operand shift registers sa and sb (WIDTH each), carry flip-flop c, result shift register sr (WIDTH), bit counter cnt (ceil(log2(WIDTH)) bits), and state register in {IDLE, SHIFT, DONE}.
- IDLE, start=1 (accept edge):
  - sa<=a, sb<=b, c<=cin, sr<=0, cnt<=0, state<=SHIFT.
  - start=0 leaves all state unchanged.
- SHIFT, every edge:
  - Compute s = sa[0]^sb[0]^c and carry = majority(sa[0],sb[0],c).
  - Shift sa and sb right by 1, filling 0 at the MSB.
  - c<=carry; sr<={s, sr[WIDTH-1:1]}, so the LSB result ends up at bit 0 after WIDTH shifts.
  - cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: state<=DONE.
- DONE: one cycle only, then state<=IDLE.
- Outputs:
  - sum = sr; cout = c.
  - busy = (state==SHIFT); done = (state==DONE).
- start is ignored in SHIFT and DONE, and is not queued. Operand inputs are ignored outside the accept edge.
- After DONE, sum and cout hold their value through IDLE until the next accept edge. On that edge sr clears to 0 and c takes the new cin.
- Arithmetic is {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.

## Timing
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, sum=0, cout=0, cnt=0, sa=sb=0.
- Latency: with the accept edge as E0, edges E1..E_WIDTH each process one bit.
  - busy=1 from after E0 until E_WIDTH.
  - done=1 for exactly the cycle between E_WIDTH and E_WIDTH+1.
- Back-to-back: with start held high, a new operation is accepted every WIDTH+2 edges: E0, E_(WIDTH+2), and so on. Each accept happens in the first IDLE cycle after DONE.
- During SHIFT, sum shows partial bits and is not valid. The only valid windows are the done cycle and the IDLE cycles that follow.
- Reset mid-operation: the operation aborts with no done pulse, and all outputs return to their reset values on that edge.
- rst and start high on the same edge: reset wins and the operation is not accepted.
- cnt never exceeds WIDTH-1, so it does not wrap during an operation.

## Test plan
- Reset: hold rst for 2 cycles with start=1 -> busy=0, done=0, sum=0, cout=0; no operation starts.
- WIDTH=64, a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0, single-cycle start -> busy high for 64 cycles, done pulses exactly 64 edges after accept, sum=0, cout=1.
- a=64'h0123_4567_89AB_CDEF, b=64'hFEDC_BA98_7654_3210, cin=1 -> sum=0, cout=1. Then a=5, b=7, cin=0 -> sum=12, cout=0; the previous result holds until the accept edge.
- Change a/b/cin every cycle and pulse start during SHIFT and during DONE -> the result equals the operands captured at E0, with no extra operation started.
- Hold start=1 for 300 cycles with a=3, b=4 -> done pulses at edges 64, 130, 196, 262 after the first accept; sum=7 each time.
- Assert rst at edge E30 of an operation -> all outputs 0 on the next cycle and no done pulse. A following start completes normally with a correct sum.
